// File: rtl/wire_line_arbiter.sv
// rtl/wire_line_arbiter.sv - round-robin arbiter sharing one registered wire line
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req          per-requester level request
//   data_in      per-requester data bit for the shared line
//   done         per-requester early release pulse
//   grant        one-hot registered grant
//   owner_id     current owner index, 0 outside GRANT
//   busy         high while in GRANT
//   line_out     registered shared line
//   line_mirror  copy of line_out
//   grant_count  saturating grant counter (only with WIRE_ARB_STATS_EN)
//
// Optional feature macro: WIRE_ARB_STATS_EN
`timescale 1ns/1ps
module wire_line_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int ID_W        = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data_in,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  owner_id,
    output logic             busy,
    output logic             line_out,
    output logic             line_mirror
`ifdef WIRE_ARB_STATS_EN
    ,
    output logic [15:0]      grant_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_d;
    logic [ID_W-1:0]  owner_d;
    logic             busy_d;
    logic             line_d;
    logic [3:0]       hold_cnt, hold_d;
    logic [ID_W-1:0]  rr_ptr, rr_d;

    logic             win_found;
    logic [ID_W-1:0]  win_idx;
    int               idx;

    // Rotating priority scan starting at rr_ptr, wrapping past N_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant;
        owner_d = owner_id;
        busy_d  = busy;
        line_d  = line_out;
        hold_d  = hold_cnt;
        rr_d    = rr_ptr;
        case (state_q)
            IDLE, GAP: begin
                // Line stays undriven on the entry edge; the owner's bit
                // first appears one edge into GRANT.
                grant_d = '0;
                owner_d = '0;
                busy_d  = 1'b0;
                line_d  = 1'b0;
                hold_d  = '0;
                if (win_found) begin
                    state_d          = GRANT;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    busy_d           = 1'b1;
                    hold_d           = 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (done[owner_id] || !req[owner_id] ||
                    (hold_cnt == 4'(HOLD_CYCLES))) begin
                    state_d = GAP;
                    grant_d = '0;
                    owner_d = '0;
                    busy_d  = 1'b0;
                    line_d  = 1'b0;
                    hold_d  = '0;
                    rr_d    = (owner_id == ID_W'(N_REQ - 1)) ? '0
                                                             : owner_id + ID_W'(1);
                end else begin
                    line_d = data_in[owner_id];
                    hold_d = hold_cnt + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = '0;
                busy_d  = 1'b0;
                line_d  = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant    <= '0;
            owner_id <= '0;
            busy     <= 1'b0;
            line_out <= 1'b0;
            hold_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            state_q  <= state_d;
            grant    <= grant_d;
            owner_id <= owner_d;
            busy     <= busy_d;
            line_out <= line_d;
            hold_cnt <= hold_d;
            rr_ptr   <= rr_d;
        end
    end

    // Single driver for both copies keeps them identical by construction.
    assign line_mirror = line_out;

`ifdef WIRE_ARB_STATS_EN
    logic enter_grant;
    assign enter_grant = (state_q != GRANT) && (state_d == GRANT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count <= '0;
        end else if (enter_grant && (grant_count != 16'hFFFF)) begin
            grant_count <= grant_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/wire_line_arbiter.md
Name: wire_line_arbiter

Overview:
- Round-robin arbiter that shares one single-bit wire line between N_REQ requesters.
- Grants one owner at a time, registers that owner's data bit onto the line and fans it out to two identical copies (primary and mirror), matching the one-in/two-out wire fan-out already in the lab.
- Bounds ownership with a hold counter and inserts a one-cycle turnaround gap between owners, so the line is never driven by two sources across a handover.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- HOLD_CYCLES, 4, maximum consecutive cycles one owner keeps the grant; legal range 1..15.
- ID_W, 2, owner_id width; must equal clog2(N_REQ).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request, level-sensitive.
- data_in  in  N_REQ  per-requester data bit to place on the line.
- done  in  N_REQ  per-requester early release, one-cycle pulse.
- grant  out  N_REQ  one-hot grant, registered.
- owner_id  out  ID_W  index of the current owner; 0 when not GRANT.
- busy  out  1  high while in GRANT.
- line_out  out  1  shared line (primary), registered.
- line_mirror  out  1  copy of line_out; always identical to it.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, grant=0, owner_id=0, busy=0, line_out=0, line_mirror=0, rr_ptr=0, hold_cnt=0.
- States: IDLE, GRANT, GAP.
- Arbitration (evaluated in IDLE and GAP):
  - Winner is the first index with req high, scanning from rr_ptr upward and wrapping N_REQ-1 -> 0.
  - If there is no req, next state is IDLE.
- IDLE -> GRANT: req sampled high at edge k gives grant and busy high after edge k. Latency is 1 clock from req to grant.
- GRANT, each edge: line_out and line_mirror take data_in[owner], so the line lags data_in by 1 clock. hold_cnt increments from 1.
- GRANT -> GAP when any of the following hold at an edge:
  - done[owner]=1;
  - req[owner]=0;
  - hold_cnt==HOLD_CYCLES.
- On leaving GRANT:
  - rr_ptr = (owner+1) mod N_REQ;
  - grant=0, busy=0, owner_id=0;
  - line_out and line_mirror forced to 0;
  - hold_cnt=0.
- GAP: lasts exactly 1 cycle with all outputs idle. Then GRANT to the arbitration winner, or IDLE if there is no req.
- done/req from non-owners are ignored during GRANT.
- Single requester held high: it is re-granted after each 1-cycle gap. Pattern is HOLD_CYCLES on, 1 off.
- done and hold expiry together: a single exit to GAP, with the same rr_ptr update.
- rr_ptr wraps from N_REQ-1 to 0.
- Reset asserted mid-GRANT: grant and line drop immediately (asynchronous). The arbiter restarts in IDLE with rr_ptr=0.
- grant is always one-hot or zero. line_out is 0 whenever busy=0.

Optional Feature:
- Macro: WIRE_ARB_STATS_EN.
- Defined:
  - Adds output port grant_count [15:0].
  - Increments on every IDLE/GAP -> GRANT transition.
  - Saturates at 16'hFFFF.
  - Resets to 0 with rst_n.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset check: rst_n=0 with req=4'b1111 -> grant=0, line_out=0, line_mirror=0, busy=0. Release rst_n, then req=4'b0100 with data_in[2]=1 -> next edge grant=4'b0100, owner_id=2; following edge line_out=line_mirror=1.
- Hold expiry: req[1] held high with HOLD_CYCLES=4 -> grant[1] high for 4 cycles, low for 1 cycle (GAP), high again; repeats.
- Round robin: req=4'b1111 from reset -> grant order 0,1,2,3,0, each 4 cycles with a 1-cycle gap between owners.
- Early release: owner 3 pulses done[3] on its 2nd grant cycle with req=4'b1001 -> GAP, then grant=4'b0001 (wrap from 3 to 0).
- Line following: owner 0 toggles data_in[0] as 0,1,0,1 -> line_out shows 0,1,0,1 one cycle later; line_mirror==line_out every cycle; line_out=0 during GAP.
- Mid-grant reset: assert rst_n=0 asynchronously on the 2nd grant cycle -> grant/line drop before the next edge. After release with req=4'b0011 -> owner 0 is granted first. With WIRE_ARB_STATS_EN defined, grant_count reads 0 after reset and 1 after that first grant.
